// File: rtl/sram_copy_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sram_copy_sequencer
//  Description : Address/strobe sequencer for the SRAM-to-SRAM evaluation
//                datapath. Sweeps MEM0/MEM1 reads over 0..SIZE and replays
//                the same addresses as MEM2/MEM3 writes LATENCY cycles later.
//                Controlled through a four-register WISHBONE slave.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_copy_sequencer #(
    parameter int WB_ADR_WIDTH   = 37,
    parameter int WB_DAT_WIDTH   = 64,
    parameter int WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int LATENCY        = 3,
    parameter int CYCLE_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WB_ADR_WIDTH-1:0]   s_wb_adr_i,
    output logic [WB_DAT_WIDTH-1:0]   s_wb_dat_o,
    input  logic [WB_DAT_WIDTH-1:0]   s_wb_dat_i,
    input  logic [WB_SEL_WIDTH-1:0]   s_wb_sel_i,
    input  logic                      s_wb_we_i,
    input  logic                      s_wb_stb_i,
    output logic                      s_wb_ack_o,
    output logic                      m_rd_en,
    output logic [MEM_ADDR_WIDTH-1:0] m_rd_addr,
    output logic                      m_wr_en,
    output logic [MEM_ADDR_WIDTH-1:0] m_wr_addr,
    output logic                      busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Pattern of the write pipeline when only its oldest entry is valid,
    // i.e. the final write of the run is on the SRAM port this cycle.
    localparam logic [LATENCY-1:0] c_head_mask = LATENCY'(1) << (LATENCY - 1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [MEM_ADDR_WIDTH-1:0] r_rd_cnt;
    logic [MEM_ADDR_WIDTH-1:0] r_size;
    logic [CYCLE_WIDTH-1:0]    r_cycles;
    logic                      r_done;
    logic [LATENCY-1:0]        r_pipe_vld;
    logic [MEM_ADDR_WIDTH-1:0] r_pipe_addr [0:LATENCY-1];

    logic [1:0]                w_adr;
    logic                      w_reg_we;
    logic                      w_start;
    logic                      w_size_we;
    logic                      w_status_clr;
    logic                      w_last_rd;
    logic                      w_finish;
    logic [WB_DAT_WIDTH-1:0]   w_rdata;
    logic                      w_unused;

    assign w_adr        = s_wb_adr_i[1:0];
    assign w_reg_we     = s_wb_stb_i & s_wb_we_i;
    assign w_start      = w_reg_we && (w_adr == 2'd0) && s_wb_dat_i[0] && (r_state == S_IDLE);
    assign w_size_we    = w_reg_we && (w_adr == 2'd2) && (r_state == S_IDLE);
    assign w_status_clr = w_reg_we && (w_adr == 2'd1) && !s_wb_dat_i[0];
    assign w_last_rd    = (r_state == S_RUN) && (r_rd_cnt == r_size);
    assign w_finish     = (r_state == S_DRAIN) && (r_pipe_vld == c_head_mask);

    // Address bits above [1:0], byte selects and upper data bits carry no meaning here.
    assign w_unused = ^{s_wb_sel_i, s_wb_adr_i[WB_ADR_WIDTH-1:2],
                        s_wb_dat_i[WB_DAT_WIDTH-1:MEM_ADDR_WIDTH]};

    assign busy       = (r_state != S_IDLE);
    assign m_rd_en    = (r_state == S_RUN);
    assign m_rd_addr  = r_rd_cnt;
    assign m_wr_en    = r_pipe_vld[LATENCY-1];
    assign m_wr_addr  = r_pipe_addr[LATENCY-1];
    assign s_wb_ack_o = s_wb_stb_i;
    assign s_wb_dat_o = w_rdata;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> DRAIN after the last read,
    // DRAIN -> IDLE once the final write has been issued.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last_rd) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_finish) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read address counter: cleared on start, advances during RUN, parks at SIZE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_cnt <= '0;
        end else if (w_start) begin
            r_rd_cnt <= '0;
        end else if ((r_state == S_RUN) && !w_last_rd) begin
            r_rd_cnt <= r_rd_cnt + MEM_ADDR_WIDTH'(1);
        end
    end

    // Write pipeline: replays {rd_en, rd_addr} exactly LATENCY cycles later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_pipe_addr[i] <= '0;
            end
        end else begin
            r_pipe_vld[0]  <= m_rd_en;
            r_pipe_addr[0] <= m_rd_addr;
            for (int i = 1; i < LATENCY; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_addr[i] <= r_pipe_addr[i-1];
            end
        end
    end

    // SIZE register: only writable while idle, so a run always sees a stable length.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_size <= '1;
        end else if (w_size_we) begin
            r_size <= s_wb_dat_i[MEM_ADDR_WIDTH-1:0];
        end
    end

    // Done flag: completion has priority over a software clear; start clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
        end else if (w_finish) begin
            r_done <= 1'b1;
        end else if (w_start || w_status_clr) begin
            r_done <= 1'b0;
        end
    end

    // Cycle counter: restarted on start, counts every busy cycle, saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycles <= '0;
        end else if (w_start) begin
            r_cycles <= '0;
        end else if (busy && (r_cycles != '1)) begin
            r_cycles <= r_cycles + CYCLE_WIDTH'(1);
        end
    end

    // Register read mux; unused upper bits read as zero.
    always_comb begin
        w_rdata = '0;
        case (w_adr)
            2'd0:    w_rdata[0] = busy;
            2'd1:    w_rdata[0] = r_done;
            2'd2:    w_rdata[MEM_ADDR_WIDTH-1:0] = r_size;
            default: w_rdata[CYCLE_WIDTH-1:0] = r_cycles;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_copy_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_copy_sequencer
//  Description : Scoreboard bench for sram_copy_sequencer. Expected read and
//                write addresses are queued when a run is launched and
//                consumed as the SRAM strobes appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_copy_sequencer;

    localparam int c_adr_w = 37;
    localparam int c_dat_w = 64;
    localparam int c_aw    = 10;
    localparam int c_lat   = 3;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [c_adr_w-1:0] s_wb_adr_i = '0;
    logic [c_dat_w-1:0] s_wb_dat_o;
    logic [c_dat_w-1:0] s_wb_dat_i = '0;
    logic [7:0]         s_wb_sel_i = 8'hFF;
    logic               s_wb_we_i = 1'b0;
    logic               s_wb_stb_i = 1'b0;
    logic               s_wb_ack_o;
    logic               m_rd_en;
    logic [c_aw-1:0]    m_rd_addr;
    logic               m_wr_en;
    logic [c_aw-1:0]    m_wr_addr;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int busy_cnt = 0;
    int wr_seen  = 0;

    int rd_q[$];
    int wr_q[$];
    int rd_cyc_q[$];

    sram_copy_sequencer #(
        .WB_ADR_WIDTH  (c_adr_w),
        .WB_DAT_WIDTH  (c_dat_w),
        .WB_SEL_WIDTH  (8),
        .MEM_ADDR_WIDTH(c_aw),
        .LATENCY       (c_lat),
        .CYCLE_WIDTH   (32)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .s_wb_adr_i(s_wb_adr_i),
        .s_wb_dat_o(s_wb_dat_o),
        .s_wb_dat_i(s_wb_dat_i),
        .s_wb_sel_i(s_wb_sel_i),
        .s_wb_we_i (s_wb_we_i),
        .s_wb_stb_i(s_wb_stb_i),
        .s_wb_ack_o(s_wb_ack_o),
        .m_rd_en   (m_rd_en),
        .m_rd_addr (m_rd_addr),
        .m_wr_en   (m_wr_en),
        .m_wr_addr (m_wr_addr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: consume scoreboard entries as strobes appear on the SRAM ports.
    always @(negedge clk) begin
        cyc++;
        if (busy) busy_cnt++;
        if (m_rd_en) begin
            if (rd_q.size() == 0) begin
                chk("rd_unexpected", 64'(m_rd_addr), 64'hFFFF);
            end else begin
                chk("rd_addr", 64'(m_rd_addr), 64'(rd_q.pop_front()));
                rd_cyc_q.push_back(cyc);
            end
        end
        if (m_wr_en) begin
            wr_seen++;
            if (wr_q.size() == 0) begin
                chk("wr_unexpected", 64'(m_wr_addr), 64'hFFFF);
            end else begin
                chk("wr_addr", 64'(m_wr_addr), 64'(wr_q.pop_front()));
                if (rd_cyc_q.size() != 0)
                    chk("wr_latency", 64'(cyc - rd_cyc_q.pop_front()), 64'(c_lat));
            end
        end
    end

    task automatic wb_write(input int adr, input logic [63:0] data);
        @(posedge clk);
        #1;
        s_wb_adr_i = c_adr_w'(adr);
        s_wb_dat_i = data;
        s_wb_we_i  = 1'b1;
        s_wb_stb_i = 1'b1;
        @(posedge clk);
        #1;
        s_wb_we_i  = 1'b0;
        s_wb_stb_i = 1'b0;
    endtask

    task automatic wb_read(input int adr, output logic [63:0] data);
        @(posedge clk);
        #1;
        s_wb_adr_i = c_adr_w'(adr);
        s_wb_we_i  = 1'b0;
        s_wb_stb_i = 1'b1;
        #1;
        chk("ack", 64'(s_wb_ack_o), 64'd1);
        data = s_wb_dat_o;
        s_wb_stb_i = 1'b0;
    endtask

    task automatic read_chk(input string tag, input int adr, input logic [63:0] exp);
        logic [63:0] d;
        wb_read(adr, d);
        chk(tag, d, exp);
    endtask

    // Queue the expected sweep, optionally program SIZE, then start.
    task automatic start_run(input int size, input bit program_size);
        for (int i = 0; i <= size; i++) begin
            rd_q.push_back(i);
            wr_q.push_back(i);
        end
        if (program_size) wb_write(2, 64'(size));
        busy_cnt = 0;
        wb_write(0, 64'd1);
    endtask

    task automatic wait_idle(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("busy_timeout", 64'(busy), 64'd0);
    endtask

    task automatic end_of_run(input string tag, input int size);
        chk({tag, "_busy_len"}, 64'(busy_cnt), 64'(size + 1 + c_lat));
        chk({tag, "_rd_left"}, 64'(rd_q.size()), 64'd0);
        chk({tag, "_wr_left"}, 64'(wr_q.size()), 64'd0);
        read_chk({tag, "_status"}, 1, 64'd1);
        read_chk({tag, "_cycles"}, 3, 64'(size + 1 + c_lat));
        read_chk({tag, "_ctl"}, 0, 64'd0);
    endtask

    initial begin
        int wr_before;
        bit hit;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rd_en", 64'(m_rd_en), 64'd0);
        chk("rst_wr_en", 64'(m_wr_en), 64'd0);
        chk("rst_rd_addr", 64'(m_rd_addr), 64'd0);
        chk("rst_wr_addr", 64'(m_wr_addr), 64'd0);
        read_chk("rst_status", 1, 64'd0);
        read_chk("rst_size", 2, 64'd1023);
        read_chk("rst_cycles", 3, 64'd0);

        // Full sweep using the reset SIZE.
        start_run(1023, 1'b0);
        wait_idle(1100);
        end_of_run("full", 1023);

        // STATUS write semantics.
        wb_write(1, 64'd1);
        read_chk("status_w1", 1, 64'd1);
        wb_write(1, 64'd0);
        read_chk("status_w0", 1, 64'd0);

        // Single-word run.
        start_run(0, 1'b1);
        wait_idle(20);
        end_of_run("size0", 0);

        // Start and SIZE writes while busy are ignored; done and CYCLES restart.
        start_run(1023, 1'b1);
        read_chk("restart_cycles", 3, 64'd1);
        read_chk("restart_status", 1, 64'd0);
        wb_write(0, 64'd1);
        wb_write(2, 64'd5);
        read_chk("busy_size", 2, 64'd1023);
        wait_idle(1100);
        end_of_run("busywr", 1023);

        // Reset in the middle of a sweep.
        start_run(1023, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (m_rd_en && (m_rd_addr == 10'd500)) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reach_addr500", 64'(hit), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd_q.delete();
        wr_q.delete();
        rd_cyc_q.delete();
        wr_before = wr_seen;
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_rd_en", 64'(m_rd_en), 64'd0);
        chk("mid_rst_wr_en", 64'(m_wr_en), 64'd0);
        repeat (20) @(negedge clk);
        chk("mid_rst_no_wr", 64'(wr_seen - wr_before), 64'd0);
        read_chk("mid_rst_size", 2, 64'd1023);

        start_run(9, 1'b1);
        wait_idle(40);
        end_of_run("after_rst", 9);

        // Register access details.
        wb_write(2, 64'h1234_5678_9ABC_DEF3);
        read_chk("size_mask", 2, 64'h2F3);
        wb_write(3, 64'hDEAD);
        read_chk("cycles_ro", 3, 64'd13);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
